// File: rtl/deadlock_idx0_monitor.sv
// Deadlock detector for dataflow region 0 of pixl_to_symbol.
// Raises block once every active process is stalled or idle long enough.
module deadlock_idx0_monitor #(
    parameter int AXIS_NUM       = 4,
    parameter int INST_NUM       = 3,
    parameter int INST_BLOCK_NUM = 1,
    parameter int CONFIRM_CYCLES = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic [AXIS_NUM-1:0]       axis_block_sigs,
    input  logic [INST_NUM-1:0]       inst_idle_sigs,
    input  logic [INST_BLOCK_NUM-1:0] inst_block_sigs,
    output logic                      block
);

    typedef enum logic {
        MONITOR = 1'b0,
        BLOCKED = 1'b1
    } state_t;

    localparam logic [7:0] LP_CONF = 8'(CONFIRM_CYCLES);
    localparam logic [7:0] LP_LAST = 8'(CONFIRM_CYCLES - 1);

    state_t     r_state;
    logic [7:0] r_cnt;

    logic w_stall0;
    logic w_stall1;
    logic w_stall2;
    logic w_quiet1;
    logic w_quiet2;
    logic w_all_idle;
    logic w_cond;

    assign w_stall0   = ~inst_idle_sigs[0] & inst_block_sigs[0];
    assign w_stall1   = ~inst_idle_sigs[1] & (axis_block_sigs[0] | axis_block_sigs[1]);
    assign w_stall2   = ~inst_idle_sigs[2] & (axis_block_sigs[2] | axis_block_sigs[3]);
    assign w_quiet1   = inst_idle_sigs[1] | w_stall1;
    assign w_quiet2   = inst_idle_sigs[2] | w_stall2;
    assign w_all_idle = inst_idle_sigs[0] & inst_idle_sigs[1] & inst_idle_sigs[2];

    // The top process never breaks a deadlock on its own, so only children gate cond.
    assign w_cond = (w_stall0 | w_stall1 | w_stall2)
                  & w_quiet1 & w_quiet2 & ~w_all_idle;

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= MONITOR;
            r_cnt   <= 8'd0;
            block   <= 1'b0;
        end else if (!w_cond) begin
            r_state <= MONITOR;
            r_cnt   <= 8'd0;
            block   <= 1'b0;
        end else begin
            if (r_cnt != LP_CONF) begin
                r_cnt <= r_cnt + 8'd1;
            end
            if (r_state == MONITOR && r_cnt == LP_LAST) begin
                r_state <= BLOCKED;
                block   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_deadlock_idx0_monitor.sv
// Randomized and directed bench for deadlock_idx0_monitor.
// Reference model tracks the length of the current qualifying run.
module tb_deadlock_idx0_monitor;

    localparam int C = 4;

    logic       clock;
    logic       reset;
    logic [3:0] axis_block_sigs;
    logic [2:0] inst_idle_sigs;
    logic [0:0] inst_block_sigs;
    logic       block;

    int tests;
    int fails;
    int run_len;

    deadlock_idx0_monitor #(
        .AXIS_NUM       (4),
        .INST_NUM       (3),
        .INST_BLOCK_NUM (1),
        .CONFIRM_CYCLES (C)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .axis_block_sigs (axis_block_sigs),
        .inst_idle_sigs  (inst_idle_sigs),
        .inst_block_sigs (inst_block_sigs),
        .block           (block)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Deadlock: some process stalled, every child idle or stalled, not all idle.
    function automatic logic model_cond(input logic [2:0] idle,
                                        input logic [3:0] axis,
                                        input logic       iblk);
        int   owner [4];
        logic stalled [3];
        logic any_stall;
        logic children_quiet;
        owner[0] = 1;
        owner[1] = 1;
        owner[2] = 2;
        owner[3] = 2;
        stalled[0] = !idle[0] && iblk;
        stalled[1] = 1'b0;
        stalled[2] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (axis[i] && !idle[owner[i]]) stalled[owner[i]] = 1'b1;
        end
        any_stall = stalled[0] || stalled[1] || stalled[2];
        children_quiet = 1'b1;
        for (int p = 1; p < 3; p++) begin
            if (!idle[p] && !stalled[p]) children_quiet = 1'b0;
        end
        return any_stall && children_quiet && (idle != 3'b111);
    endfunction

    task automatic step(input string tag, input logic rst,
                        input logic [2:0] idle, input logic [3:0] axis,
                        input logic iblk);
        logic exp;
        @(negedge clock);
        reset           = rst;
        inst_idle_sigs  = idle;
        axis_block_sigs = axis;
        inst_block_sigs = iblk;
        @(posedge clock);
        if (rst) run_len = 0;
        else if (model_cond(idle, axis, iblk)) run_len = (run_len < 1000) ? run_len + 1 : run_len;
        else run_len = 0;
        exp = (run_len >= C);
        #1;
        tests++;
        assert (block === exp) else begin
            fails++;
            $error("FAIL %s: block=%b expected %b (idle=%b axis=%b rst=%b)",
                   tag, block, exp, idle, axis, rst);
        end
    endtask

    initial begin
        logic [2:0] r_idle;
        logic [3:0] r_axis;
        logic       r_iblk;
        logic       r_rst;
        int         hold;
        tests   = 0;
        fails   = 0;
        run_len = 0;
        reset           = 1'b1;
        inst_idle_sigs  = 3'b110;
        axis_block_sigs = 4'b0000;
        inst_block_sigs = 1'b0;

        repeat (2) step("reset", 1'b1, 3'b110, 4'b0000, 1'b0);
        repeat (20) step("idle", 1'b0, 3'b110, 4'b0000, 1'b0);

        step("rst1", 1'b1, 3'b100, 4'b0000, 1'b0);
        repeat (6) step("single_stall", 1'b0, 3'b100, 4'b0001, 1'b0);

        step("rst2", 1'b1, 3'b000, 4'b0000, 1'b0);
        repeat (20) step("partial", 1'b0, 3'b000, 4'b0010, 1'b0);

        repeat (6) step("both_stall", 1'b0, 3'b000, 4'b1001, 1'b0);
        repeat (2) step("release", 1'b0, 3'b000, 4'b0001, 1'b0);

        repeat (3) step("win_pre", 1'b0, 3'b000, 4'b1001, 1'b0);
        step("win_drop", 1'b0, 3'b000, 4'b0010, 1'b0);
        repeat (5) step("win_restart", 1'b0, 3'b000, 4'b1001, 1'b0);

        repeat (2) step("mid_hold", 1'b0, 3'b000, 4'b1001, 1'b0);
        step("mid_reset", 1'b1, 3'b000, 4'b1001, 1'b0);
        repeat (5) step("post_reset", 1'b0, 3'b000, 4'b1001, 1'b0);

        // Hold each random pattern several cycles so windows complete.
        for (int n = 0; n < 120; n++) begin
            r_idle = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) != 0) r_idle[0] = 1'b0;
            r_axis = 4'($urandom_range(0, 15));
            r_iblk = ($urandom_range(0, 5) == 0);
            r_rst  = ($urandom_range(0, 19) == 0);
            hold   = $urandom_range(1, 8);
            for (int h = 0; h < hold; h++) begin
                step("random", (h == 0) ? r_rst : 1'b0, r_idle, r_axis, r_iblk);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/deadlock_idx0_monitor.md
# deadlock_idx0_monitor

Deadlock detector for dataflow region index 0 of the `pixl_to_symbol` kernel; it is simulation/debug infrastructure with no datapath role. It samples per-process idle flags and per-AXI-Stream blocking flags from the top process (process 0) and its two pipeline sub-processes (VITIS_LOOP_22_1 = process 1, VITIS_LOOP_48_2 = process 2). It asserts `block` once every active process has been stalled or idle, with at least one stalled, for a confirmation window. The kernel-level monitor wrapper consumes `block` and reports the first rising edge.

## Interface
- `AXIS_NUM`, 4, number of AXI-Stream blocking flags.
- `INST_NUM`, 3, number of processes with idle flags.
- `INST_BLOCK_NUM`, 1, number of direct instance-block flags.
- `CONFIRM_CYCLES`, 4, consecutive qualifying cycles before `block` asserts; legal range 1..255.
- `clock`  in  1  sole clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `axis_block_sigs`  in  AXIS_NUM  bit i = 1 means stream port i is stalled (TDATA_blk_n low). Bit 0: process 1 data_in. Bit 1: process 1 data_out. Bit 2: process 2 data_out. Bit 3: process 2 data_in.
- `inst_idle_sigs`  in  INST_NUM  bit p = 1 means process p is idle (ap_idle). Bit 0 (top) is tied 0 by the wrapper.
- `inst_block_sigs`  in  INST_BLOCK_NUM  bit 0 = 1 means the top process is directly blocked (tied 0 by the wrapper).
- `block`  out  1  registered deadlock indication.

## Operation
- Inputs are level signals sampled every rising edge; no input registering is required beyond the state below.
- Per-process stall, combinational:
  - `stall1 = ~idle[1] & (axis[0] | axis[1])`
  - `stall2 = ~idle[2] & (axis[2] | axis[3])`
  - `stall0 = ~idle[0] & inst_block[0]`
- Per-child quiet: `quiet_p = idle[p] | stall_p`, for p = 1, 2.
- Top process, when not idle, is always treated as waiting on its children; it never breaks a deadlock by itself.
- Qualifying condition: `cond = (stall0 | stall1 | stall2) & quiet1 & quiet2 & ~(idle[0] & idle[1] & idle[2])`.
- All-idle never qualifies. Any non-idle child with no asserted stream flag disqualifies.
- Confirmation counter `cnt`, 8 bits:
  - `cond` = 1: increment, saturating at CONFIRM_CYCLES.
  - `cond` = 0: clear to 0.
- State machine, two states:
  - MONITOR (block = 0): go to BLOCKED on the edge where `cond` = 1 and `cnt` == CONFIRM_CYCLES-1. For CONFIRM_CYCLES = 1, go to BLOCKED on the first qualifying edge.
  - BLOCKED (block = 1): stay while `cond` = 1. Return to MONITOR and clear `cnt` on the first edge with `cond` = 0.
- Stream-flag bits belonging to an idle process are ignored.
- No X-propagation handling is required; X inputs make `cond` X.

## Timing
- Reset: `block` = 0, `cnt` = 0, state MONITOR, on the first rising edge with `reset` = 1.
- Reset has priority over all other updates, including mid-confirmation and while BLOCKED: `block` drops on that edge.
- Assertion latency: with `cond` high from edge k onward, `block` = 1 after edge k+CONFIRM_CYCLES-1, i.e. at the CONFIRM_CYCLES-th qualifying edge.
- Deassertion latency: `block` = 0 after the first edge sampling `cond` = 0.
- A single-cycle `cond` drop restarts the full confirmation window.
- `block` is glitch-free, driven directly from a flop.

## Test plan
- Reset/idle: hold `reset` 2 cycles, then drive `inst_idle_sigs` = 3'b110 and `axis_block_sigs` = 0 for 20 cycles -> `block` stays 0 throughout.
- Single-process stall: `inst_idle_sigs` = 3'b100, `axis_block_sigs` = 4'b0001 held -> `block` rises exactly at the 4th qualifying edge and stays 1.
- Partial stall: `inst_idle_sigs` = 3'b000, `axis_block_sigs` = 4'b0010 (process 2 running, unstalled) for 20 cycles -> `block` stays 0.
- Both stalled, then release: `inst_idle_sigs` = 3'b000, `axis_block_sigs` = 4'b1001 -> `block` = 1 after 4 edges. Set `axis_block_sigs` = 4'b0001 -> `block` = 0 on the next edge.
- Window restart: qualifying pattern for 3 cycles, one non-qualifying cycle, then qualifying again -> `block` rises only 4 edges after the restart.
- Reset mid-block: while `block` = 1 with `cond` held, pulse `reset` 1 cycle -> `block` = 0 on that edge, re-asserts 4 edges after reset release.
